minplus_reduce_ctrl: RTL and testbench
======================================

# minplus_reduce_ctrl

Streaming sequencer around a 5-input unsigned min unit for min-plus (tropical) tensor-core reductions. Each input beat carries four W-bit lanes. A running accumulator occupies the fifth min input. A vector of any number of beats, terminated by `in_last`, is folded to a single minimum, which is presented on a valid/ready output port. The block sits between the min-plus partial-product stage and the writeback/accumulate stage.

## Interface
- `W`, 16: element width; elements are unsigned.
- `CNT_W`, 16: width of the beat counter and of the argmin index.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input beat accepted when `in_valid && in_ready`.
- `in_data` in 4*W: lane k at bits [k*W +: W].
- `in_keep` in 4: lane enable; masked lanes are treated as all-ones (the min identity).
- `in_last` in 1: final beat of the current vector.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumed when `out_valid && out_ready`.
- `out_data` out W: minimum over all kept lanes of the vector.
- `out_count` out CNT_W: number of beats accepted in the vector.
- `out_idx` out CNT_W: argmin element index. Present only with `MINRED_ARGMIN_EN`.

## Operation
- The clock is `clk`. Reset `rst` is asynchronous and active-high.
- State machine has two states, ACC and HOLD. Reset state is ACC.
- Reset values:
  - `acc` = all-ones; `beat_cnt` = 0.
  - `out_valid` = 0; `out_data` = 0; `out_count` = 0; `out_idx` = 0.
- `in_ready` is 1 in ACC and 0 in HOLD. It is combinational from state only.
- On each accepted beat in ACC:
  - `m` = min5(acc, lane0..lane3), with masked lanes forced to all-ones.
  - `beat_cnt` increments and saturates at 2^CNT_W-1.
- Accepted beat with `in_last` = 0: `acc` <= `m`. State stays ACC.
- Accepted beat with `in_last` = 1:
  - `out_data` <= `m`; `out_count` <= `beat_cnt`+1 (saturating).
  - `out_valid` <= 1.
  - `acc` <= all-ones; `beat_cnt` <= 0.
  - Next state is HOLD.
- In HOLD, outputs are frozen until `out_ready`. Then `out_valid` <= 0 and next state is ACC.
- Comparison is unsigned and W bits wide. There is no arithmetic widening.
- Tie priority for equal values, highest first: accumulator, then lane0, lane1, lane2, lane3. The earliest element in stream order wins.
- All-masked vector, i.e. `in_keep` = 0 on every beat:
  - `out_data` = all-ones; `out_idx` = 0.
  - `out_count` = the number of beats.
- `in_keep`, `in_data` and `in_last` are ignored whenever no handshake occurs.
- Reset asserted mid-vector discards the partial accumulation and any pending output.

## Timing
- Latency: `out_valid` rises on the cycle after the handshake of the `in_last` beat.
- Throughput:
  - One beat per cycle within a vector.
  - Exactly one bubble cycle of `in_ready` = 0 between vectors when `out_ready` is held at 1.
  - Further bubbles while the consumer stalls.
- `out_valid`, once high, stays high with stable `out_data`, `out_count` and `out_idx` until the output handshake.
- min5 is combinational within one cycle. There is no internal pipeline register.
- Single-beat vector (`in_last` on the first beat): same one-cycle latency; `out_count` = 1.

## Configuration
- `MINRED_ARGMIN_EN` defined:
  - An index accumulator `acc_idx` is added; its reset value is 0.
  - Lane k of beat b has element index b*4+k, truncated to CNT_W bits.
  - `acc_idx` follows the winning input of min5 under the tie priority above. It is cleared with `acc`.
  - The `out_idx` port is present and latched alongside `out_data`.
- `MINRED_ARGMIN_EN` not defined:
  - No index logic.
  - The `out_idx` port is absent.

## Structure
- Shared package `minred_pkg` contains:
  - the lane count constant `LANES` = 4;
  - the all-ones identity function `min_ident(W)`;
  - the state enum `minred_state_t` {ACC, HOLD}.
- One sub-module, `min5_tree`:
  - Combinational 5-input unsigned min.
  - Optional index-carry outputs under the same macro.
  - Input 0 has the highest tie priority.
- The top level contains only the FSM, counters, accumulator and output registers.

## Test plan
- Reset, then an idle cycle:
  - `out_valid` = 0 and `in_ready` = 1.
- Two-beat vector, W=16:
  - Beats {9,7,12,30} and {5,40,5,8}, last on beat 2, `out_ready` = 1.
  - Expect `out_data` = 5, `out_count` = 2, `out_idx` = 4.
  - Expect `in_ready` = 0 for exactly one cycle.
- Back-pressure:
  - Same vector with `out_ready` held at 0 for 5 cycles.
  - Expect `out_valid` and the outputs stable and `in_ready` = 0 throughout.
  - Expect the handshake on cycle 6.
- Masking:
  - Single beat {0,3,3,0} with `in_keep` = 4'b0110.
  - Expect `out_data` = 3 and `out_idx` = 1, with the tie resolved to the lower lane.
- All-masked vector of three beats:
  - Expect `out_data` = 16'hFFFF, `out_count` = 3, `out_idx` = 0.
- Reset mid-vector:
  - Assert `rst` after beat 1 of a vector whose minimum is 2.
  - Then send a new single beat {50,60,70,80}.
  - Expect `out_data` = 50, `out_count` = 1.

Source files
------------

// File: rtl/minred_pkg.sv
`default_nettype none
// ============================================================================
// Module   : minred_pkg
// Purpose  : Shared definitions for the min-plus reduction sequencer:
//            lane count, min identity helper and FSM state type.
// Macros   : MINRED_ARGMIN_EN (consumed by min5_tree / minplus_reduce_ctrl)
// Revision : 1.0 - initial release
// ============================================================================
package minred_pkg;

  // Number of W-bit lanes carried by one input beat.
  localparam int LANES = 4;

  // Widest element supported by min_ident; callers cast down to their width.
  localparam int MAX_IDENT_W = 64;

  // All-ones value of width w: the identity element of unsigned min.
  function automatic logic [MAX_IDENT_W-1:0] min_ident(input int w);
    if (w >= MAX_IDENT_W) begin
      min_ident = '1;
    end else begin
      min_ident = (64'd1 << w) - 64'd1;
    end
  endfunction

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } minred_state_t;

endpackage : minred_pkg
`default_nettype wire

// File: rtl/min5_tree.sv
`default_nettype none
// ============================================================================
// Module   : min5_tree
// Purpose  : Combinational 5-input unsigned minimum. Input 0 has the highest
//            tie priority, input 4 the lowest.
// Ports    : in_val  - five W-bit candidates (index 0 = highest priority)
//            in_idx  - element index carried with each candidate (argmin)
//            out_min - smallest candidate
//            out_idx - index carried by the winning candidate (argmin)
// Macros   : MINRED_ARGMIN_EN adds the in_idx/out_idx index-carry path.
// Revision : 1.0 - initial release
// ============================================================================
module min5_tree #(
  parameter int W = 16
`ifdef MINRED_ARGMIN_EN
  ,
  parameter int IDX_W = 16
`endif
) (
  input  logic [4:0][W-1:0]     in_val,
`ifdef MINRED_ARGMIN_EN
  input  logic [4:0][IDX_W-1:0] in_idx,
  output logic [IDX_W-1:0]      out_idx,
`endif
  output logic [W-1:0]          out_min
);

  // A strict less-than scan in priority order means an equal later
  // candidate never displaces an earlier one.
  always_comb begin
    out_min = in_val[0];
`ifdef MINRED_ARGMIN_EN
    out_idx = in_idx[0];
`endif
    for (int i = 1; i < 5; i++) begin
      if (in_val[i] < out_min) begin
        out_min = in_val[i];
`ifdef MINRED_ARGMIN_EN
        out_idx = in_idx[i];
`endif
      end
    end
  end

endmodule : min5_tree
`default_nettype wire

// File: rtl/minplus_reduce_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : minplus_reduce_ctrl
// Purpose  : Streaming sequencer folding a vector of 4-lane beats (terminated
//            by in_last) into a single unsigned minimum, delivered on a
//            valid/ready output port.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready/in_data/in_keep/in_last - input beat stream
//            out_valid/out_ready                       - result handshake
//            out_data  - minimum over all kept lanes of the vector
//            out_count - beats accepted in the vector (saturating)
//            out_idx   - argmin element index (MINRED_ARGMIN_EN only)
// Macros   : MINRED_ARGMIN_EN enables the argmin index path and out_idx.
// Revision : 1.0 - initial release
// ============================================================================
module minplus_reduce_ctrl
  import minred_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_data,
  input  logic [LANES-1:0]     in_keep,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [CNT_W-1:0]     out_count
`ifdef MINRED_ARGMIN_EN
  ,
  output logic [CNT_W-1:0]     out_idx
`endif
);

  localparam logic [W-1:0] c_ident = W'(min_ident(W));

  minred_state_t    state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic [4:0][W-1:0] w_min_in;
  logic [W-1:0]      w_min;
  logic [CNT_W-1:0]  w_cnt_inc;

`ifdef MINRED_ARGMIN_EN
  logic [CNT_W-1:0]      acc_idx_q, acc_idx_d;
  logic [CNT_W-1:0]      out_idx_q, out_idx_d;
  logic [4:0][CNT_W-1:0] w_idx_in;
  logic [CNT_W-1:0]      w_min_idx;
`endif

  // Accumulator sits on the highest-priority input so a tie keeps the
  // element seen earliest in the stream.
  always_comb begin
    w_min_in[0] = acc_q;
    for (int k = 0; k < LANES; k++) begin
      w_min_in[k+1] = in_keep[k] ? in_data[k*W +: W] : c_ident;
    end
  end

`ifdef MINRED_ARGMIN_EN
  // Element index of lane k in beat b is b*LANES + k, wrapped to CNT_W bits.
  always_comb begin
    w_idx_in[0] = acc_idx_q;
    for (int k = 0; k < LANES; k++) begin
      w_idx_in[k+1] = (beat_cnt_q << 2) | CNT_W'(k);
    end
  end
`endif

  min5_tree #(
    .W     (W)
`ifdef MINRED_ARGMIN_EN
    ,
    .IDX_W (CNT_W)
`endif
  ) u_min5 (
    .in_val  (w_min_in),
`ifdef MINRED_ARGMIN_EN
    .in_idx  (w_idx_in),
    .out_idx (w_min_idx),
`endif
    .out_min (w_min)
  );

  assign w_cnt_inc = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + CNT_W'(1);

  // in_ready depends on state only, so it never combinationally loops
  // through the upstream valid.
  assign in_ready = (state_q == ACC);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
`ifdef MINRED_ARGMIN_EN
    acc_idx_d   = acc_idx_q;
    out_idx_d   = out_idx_q;
`endif
    case (state_q)
      ACC: begin
        if (in_valid) begin
          if (in_last) begin
            out_data_d  = w_min;
            out_count_d = w_cnt_inc;
            out_valid_d = 1'b1;
            acc_d       = c_ident;
            beat_cnt_d  = '0;
`ifdef MINRED_ARGMIN_EN
            out_idx_d   = w_min_idx;
            acc_idx_d   = '0;
`endif
            state_d     = HOLD;
          end else begin
            acc_d      = w_min;
            beat_cnt_d = w_cnt_inc;
`ifdef MINRED_ARGMIN_EN
            acc_idx_d  = w_min_idx;
`endif
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= c_ident;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
`ifdef MINRED_ARGMIN_EN
      acc_idx_q   <= '0;
      out_idx_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
`ifdef MINRED_ARGMIN_EN
      acc_idx_q   <= acc_idx_d;
      out_idx_q   <= out_idx_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
`ifdef MINRED_ARGMIN_EN
  assign out_idx   = out_idx_q;
`endif

endmodule : minplus_reduce_ctrl
`default_nettype wire

// File: tb/tb_minplus_reduce_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_minplus_reduce_ctrl
// Purpose  : Self-checking bench for minplus_reduce_ctrl (W=16, CNT_W=16).
//            Covers MINRED_ARGMIN_EN when the macro is defined for the build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_minplus_reduce_ctrl;

  localparam int W     = 16;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4*W-1:0]    in_data = '0;
  logic [3:0]        in_keep = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [W-1:0]      out_data;
  logic [CNT_W-1:0]  out_count;
`ifdef MINRED_ARGMIN_EN
  logic [CNT_W-1:0]  out_idx;
`endif

  int checks = 0;
  int errors = 0;

  // Current vector under test: one entry per beat.
  logic [63:0] q_data[$];
  logic [3:0]  q_keep[$];

  // Model results.
  logic [W-1:0]     exp_data;
  logic [CNT_W-1:0] exp_count;
  logic [CNT_W-1:0] exp_idx;

  always #5 clk = ~clk;

  minplus_reduce_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef MINRED_ARGMIN_EN
    .out_idx   (out_idx),
`endif
    .out_count (out_count)
  );

  // Reference: walk every kept element in stream order; a strictly smaller
  // value takes over, so the earliest of equal minima is reported.
  function automatic void model_vector();
    int best;
    int best_idx;
    best     = 65535;
    best_idx = 0;
    for (int b = 0; b < q_data.size(); b++) begin
      for (int k = 0; k < 4; k++) begin
        if (q_keep[b][k]) begin
          int v;
          v = int'((q_data[b] >> (16 * k)) & 64'hFFFF);
          if (v < best) begin
            best     = v;
            best_idx = (b * 4 + k) % 65536;
          end
        end
      end
    end
    exp_data  = W'(best);
    exp_idx   = CNT_W'(best_idx);
    exp_count = CNT_W'(q_data.size());
  endfunction

  function automatic logic [63:0] pack4(input int l0, input int l1, input int l2, input int l3);
    pack4 = {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  // Fill the non-handshake inputs with junk so they are proven ignored.
  task automatic scramble_idle();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_keep  = 4'($urandom);
    in_last  = 1'($urandom);
  endtask

  // Offer one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input logic [63:0] d, input logic [3:0] k, input logic l);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    while (in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL beat_accept: in_ready=%b required 1 (timeout)", in_ready);
    end
    @(posedge clk); #1;
    scramble_idle();
  endtask

  // Send q_data/q_keep with optional idle gaps; returns 1 cycle after the
  // handshake of the last beat.
  task automatic drive_vector(input int max_gap);
    for (int b = 0; b < q_data.size(); b++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        scramble_idle();
        @(posedge clk); #1;
      end
      send_beat(q_data[b], q_keep[b], (b == q_data.size() - 1));
    end
  endtask

  task automatic release_output();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic load_two_beat();
    q_data = {};
    q_keep = {};
    q_data.push_back(pack4(9, 7, 12, 30));  q_keep.push_back(4'hF);
    q_data.push_back(pack4(5, 40, 5, 8));   q_keep.push_back(4'hF);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++;
    if (out_data !== '0 || out_count !== '0) begin
      errors++;
      $display("FAIL reset_outputs: data=%0d count=%0d required 0 0", out_data, out_count);
    end
  endtask

  task automatic test_two_beat();
    load_two_beat();
    model_vector();
    drive_vector(0);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL two_beat_latency: out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
    end
    checks++;
    if (out_data !== exp_data || out_data !== 16'd5) begin
      errors++; $display("FAIL two_beat_data: got %0d required 5", out_data);
    end
    checks++;
    if (out_count !== exp_count || out_count !== 16'd2) begin
      errors++; $display("FAIL two_beat_count: got %0d required 2", out_count);
    end
`ifdef MINRED_ARGMIN_EN
    checks++;
    if (out_idx !== exp_idx || out_idx !== 16'd4) begin
      errors++; $display("FAIL two_beat_idx: got %0d required 4", out_idx);
    end
`endif
    release_output();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL two_beat_bubble: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    load_two_beat();
    model_vector();
    drive_vector(0);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_data || out_count !== exp_count) begin
        errors++;
        $display("FAIL backpressure_hold c=%0d: valid=%b ready=%b data=%0d count=%0d required 1 0 %0d %0d",
                 c, out_valid, in_ready, out_data, out_count, exp_data, exp_count);
      end
`ifdef MINRED_ARGMIN_EN
      checks++;
      if (out_idx !== exp_idx) begin
        errors++; $display("FAIL backpressure_idx c=%0d: got %0d required %0d", c, out_idx, exp_idx);
      end
`endif
      @(posedge clk); #1;
    end
    release_output();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_masking();
    q_data = {};
    q_keep = {};
    q_data.push_back(pack4(0, 3, 3, 0)); q_keep.push_back(4'b0110);
    model_vector();
    drive_vector(0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd3 || out_count !== 16'd1) begin
      errors++;
      $display("FAIL masking: valid=%b data=%0d count=%0d required 1 3 1", out_valid, out_data, out_count);
    end
`ifdef MINRED_ARGMIN_EN
    checks++;
    if (out_idx !== 16'd1) begin
      errors++; $display("FAIL masking_idx: got %0d required 1", out_idx);
    end
`endif
    release_output();
  endtask

  task automatic test_all_masked();
    q_data = {};
    q_keep = {};
    for (int b = 0; b < 3; b++) begin
      q_data.push_back({$urandom, $urandom});
      q_keep.push_back(4'b0000);
    end
    drive_vector(0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hFFFF || out_count !== 16'd3) begin
      errors++;
      $display("FAIL all_masked: valid=%b data=%h count=%0d required 1 ffff 3", out_valid, out_data, out_count);
    end
`ifdef MINRED_ARGMIN_EN
    checks++;
    if (out_idx !== 16'd0) begin
      errors++; $display("FAIL all_masked_idx: got %0d required 0", out_idx);
    end
`endif
    release_output();
  endtask

  task automatic test_reset_mid();
    send_beat(pack4(10, 2, 90, 33), 4'hF, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_state: valid=%b ready=%b required 0 1", out_valid, in_ready);
    end
    q_data = {};
    q_keep = {};
    q_data.push_back(pack4(50, 60, 70, 80)); q_keep.push_back(4'hF);
    drive_vector(0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd50 || out_count !== 16'd1) begin
      errors++;
      $display("FAIL reset_mid_result: valid=%b data=%0d count=%0d required 1 50 1", out_valid, out_data, out_count);
    end
`ifdef MINRED_ARGMIN_EN
    checks++;
    if (out_idx !== 16'd0) begin
      errors++; $display("FAIL reset_mid_idx: got %0d required 0", out_idx);
    end
`endif
    release_output();
  endtask

  // Random vectors with narrow value range (many ties), random masks,
  // idle gaps carrying junk, and random consumer stalls.
  task automatic test_random();
    for (int v = 0; v < 40; v++) begin
      int len;
      int stall;
      len   = int'($urandom_range(1, 7));
      stall = int'($urandom_range(0, 3));
      q_data = {};
      q_keep = {};
      for (int b = 0; b < len; b++) begin
        q_data.push_back(pack4(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                               int'($urandom_range(0, 20)), int'($urandom_range(0, 20))));
        q_keep.push_back(($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom));
      end
      model_vector();
      drive_vector(2);
      for (int c = 0; c <= stall; c++) begin
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_data || out_count !== exp_count) begin
          errors++;
          $display("FAIL random v=%0d c=%0d: valid=%b ready=%b data=%0d count=%0d required 1 0 %0d %0d",
                   v, c, out_valid, in_ready, out_data, out_count, exp_data, exp_count);
        end
`ifdef MINRED_ARGMIN_EN
        checks++;
        if (out_idx !== exp_idx) begin
          errors++; $display("FAIL random_idx v=%0d: got %0d required %0d", v, out_idx, exp_idx);
        end
`endif
        if (c < stall) begin
          @(posedge clk); #1;
        end
      end
      release_output();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL random_release v=%0d: out_valid=%b required 0", v, out_valid);
      end
    end
  endtask

  initial begin
    scramble_idle();
    test_reset();
    test_two_beat();
    test_backpressure();
    test_masking();
    test_all_masked();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_minplus_reduce_ctrl
`default_nettype wire
